// File: rtl/spi_slave.sv
// SPI mode-3 (CPOL=1, CPHA=1) slave, MSB first, 8-bit bytes, oversampled in the clk domain.
// Build option SPI_SLAVE_ECHO_EN: empty byte slots resend the last received byte instead of TX_DEFAULT.
module spi_slave #(
  parameter int         SYNC_STAGES = 2,
  parameter logic [7:0] TX_DEFAULT  = 8'hFF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] tx_byte,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_byte,
  output logic       rx_valid,
  output logic       busy,
  input  logic       SS,
  input  logic       SCK,
  input  logic       MOSI,
  output logic       MISO,
  output logic       MISO_oe
);

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_ACTIVE = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] ss_sync_r;
  logic [SYNC_STAGES-1:0] sck_sync_r;
  logic [SYNC_STAGES-1:0] mosi_sync_r;
  logic                   sck_d_r;
  logic                   ss_s;
  logic                   sck_s;
  logic                   mosi_s;
  logic                   rise_s;
  logic                   fall_s;
  state_t                 state_r;
  state_t                 state_nxt_s;
  logic                   abort_s;
  logic                   do_rise_s;
  logic                   do_fall_s;
  logic                   slot_load_s;
  logic [2:0]             bit_cnt_r;
  logic [6:0]             rx_shift_r;
  logic [6:0]             tx_shift_r;
  logic [7:0]             hold_r;
  logic [7:0]             load_byte_s;
  logic [7:0]             default_byte_s;
  logic                   tx_ready_r;
  logic [7:0]             rx_byte_r;
  logic                   rx_valid_r;
  logic                   busy_r;
  logic                   miso_r;

  // Pin synchronizers, reset to idle bus levels so no false edge appears after reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      ss_sync_r   <= {SYNC_STAGES{1'b1}};
      sck_sync_r  <= {SYNC_STAGES{1'b1}};
      mosi_sync_r <= {SYNC_STAGES{1'b0}};
      sck_d_r     <= 1'b1;
    end else begin
      ss_sync_r   <= {ss_sync_r[SYNC_STAGES-2:0], SS};
      sck_sync_r  <= {sck_sync_r[SYNC_STAGES-2:0], SCK};
      mosi_sync_r <= {mosi_sync_r[SYNC_STAGES-2:0], MOSI};
      sck_d_r     <= sck_s;
    end
  end

  assign ss_s   = ss_sync_r[SYNC_STAGES-1];
  assign sck_s  = sck_sync_r[SYNC_STAGES-1];
  assign mosi_s = mosi_sync_r[SYNC_STAGES-1];
  assign rise_s = ~sck_d_r & sck_s;
  assign fall_s = sck_d_r & ~sck_s;

  // Frame FSM next state
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!ss_s) state_nxt_s = ST_ACTIVE;
        else       state_nxt_s = ST_IDLE;
      end
      ST_ACTIVE: begin
        if (ss_s) state_nxt_s = ST_IDLE;
        else      state_nxt_s = ST_ACTIVE;
      end
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // An SS release outranks any SCK edge seen in the same cycle.
  assign abort_s     = (state_r == ST_ACTIVE) & ss_s;
  assign do_rise_s   = (state_r == ST_ACTIVE) & ~ss_s & rise_s;
  assign do_fall_s   = (state_r == ST_ACTIVE) & ~ss_s & fall_s;
  assign slot_load_s = do_fall_s & (bit_cnt_r == 3'd0);

`ifdef SPI_SLAVE_ECHO_EN
  assign default_byte_s = rx_byte_r;
`else
  assign default_byte_s = TX_DEFAULT;
`endif

  // Byte loaded at a slot start: held byte (pre-handshake contents) or the default
  always_comb begin
    load_byte_s = default_byte_s;
    if (!tx_ready_r) load_byte_s = hold_r;
    else             load_byte_s = default_byte_s;
  end

  // FSM state register and frame-active flag
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
      busy_r  <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      busy_r  <= (state_nxt_s == ST_ACTIVE);
    end
  end

  // TX holding register; a slot consumes it before a same-cycle handshake can refill it.
  always_ff @(posedge clk) begin
    if (rst) begin
      hold_r     <= 8'h00;
      tx_ready_r <= 1'b1;
    end else if (slot_load_s && !tx_ready_r) begin
      tx_ready_r <= 1'b1;
    end else if (tx_valid && tx_ready_r) begin
      hold_r     <= tx_byte;
      tx_ready_r <= 1'b0;
    end
  end

  // Bit counter, shift registers, received byte and MISO
  always_ff @(posedge clk) begin
    if (rst) begin
      bit_cnt_r  <= 3'd0;
      rx_shift_r <= 7'd0;
      tx_shift_r <= 7'd0;
      rx_byte_r  <= 8'h00;
      rx_valid_r <= 1'b0;
      miso_r     <= 1'b1;
    end else begin
      rx_valid_r <= 1'b0;
      if (abort_s) begin
        bit_cnt_r  <= 3'd0;
        rx_shift_r <= 7'd0;
        miso_r     <= 1'b1;
      end else begin
        if (do_fall_s) begin
          if (bit_cnt_r == 3'd0) begin
            tx_shift_r <= load_byte_s[6:0];
            miso_r     <= load_byte_s[7];
          end else begin
            miso_r <= tx_shift_r[3'd7 - bit_cnt_r];
          end
        end
        if (do_rise_s) begin
          rx_shift_r <= {rx_shift_r[5:0], mosi_s};
          bit_cnt_r  <= bit_cnt_r + 3'd1;
          if (bit_cnt_r == 3'd7) begin
            rx_byte_r  <= {rx_shift_r, mosi_s};
            rx_valid_r <= 1'b1;
          end
        end
      end
    end
  end

  assign tx_ready = tx_ready_r;
  assign rx_byte  = rx_byte_r;
  assign rx_valid = rx_valid_r;
  assign busy     = busy_r;
  assign MISO     = miso_r;
  assign MISO_oe  = busy_r;

endmodule

// File: tb/tb_spi_slave.sv
// Directed bench for spi_slave: a bit-level SPI master plus a byte-level model of the slave's
// holding register and received-byte stream, checked on every clk.
module tb_spi_slave;

  localparam int S = 2;  // SYNC_STAGES
  localparam int H = 8;  // SCK half period in clk cycles

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] tx_byte;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       busy;
  logic       SS;
  logic       SCK;
  logic       MOSI;
  logic       MISO;
  logic       MISO_oe;

  int total = 0;
  int bad   = 0;

  logic [7:0] rx_q[$];
  logic [7:0] m_hold;
  bit         m_full;
  logic [7:0] m_last_rx;
  bit         checking;
  logic [2:0] ss_hist = 3'b111;
  logic       prev_rx_valid = 1'b0;

  logic [7:0] g0, g1, e0, e1;

  spi_slave #(.SYNC_STAGES(S), .TX_DEFAULT(8'hFF)) dut (
    .clk(clk), .rst(rst), .tx_byte(tx_byte), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_byte(rx_byte), .rx_valid(rx_valid), .busy(busy),
    .SS(SS), .SCK(SCK), .MOSI(MOSI), .MISO(MISO), .MISO_oe(MISO_oe)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] empty_slot_byte();
`ifdef SPI_SLAVE_ECHO_EN
    return m_last_rx;
`else
    return 8'hFF;
`endif
  endfunction

  // SS as seen at each clk edge; busy follows !SS through the sync chain plus the state flop
  always @(posedge clk) ss_hist <= {ss_hist[1:0], SS};

  // Per-cycle compare against the model
  always @(negedge clk) begin
    if (checking) begin
      check("oe_eq_busy", MISO_oe, busy);
      check("busy_latency", busy, !ss_hist[2]);
      if (!busy) check("miso_idle_high", MISO, 1'b1);
      if (rx_valid) begin
        check("rx_valid_one_cycle", prev_rx_valid, 1'b0);
        if (rx_q.size() == 0) begin
          total++;
          bad++;
          $display("FAIL rx_unexpected: got rx_byte %0h expected no strobe", rx_byte);
        end else begin
          logic [7:0] exp;
          exp = rx_q.pop_front();
          check("rx_byte", rx_byte, exp);
          m_last_rx = exp;
        end
      end
    end
    prev_rx_valid = rx_valid;
  end

  task automatic tx_load(input logic [7:0] d);
    int n = 0;
    @(negedge clk);
    while (!tx_ready && n < 300) begin
      @(negedge clk);
      n++;
    end
    if (!tx_ready) begin
      total++;
      bad++;
      $display("FAIL tx_ready_timeout: got tx_ready 0 expected 1 within 300 cycles");
    end else begin
      tx_byte  = d;
      tx_valid = 1'b1;
      @(negedge clk);
      tx_valid = 1'b0;
      m_hold   = d;
      m_full   = 1'b1;
      check("tx_ready_drop", tx_ready, 1'b0);
    end
  endtask

  task automatic frame_start();
    @(negedge clk);
    SS = 1'b0;
    repeat (H) @(negedge clk);
  endtask

  task automatic frame_end();
    repeat (H) @(negedge clk);
    SS = 1'b1;
    repeat (2 * H) @(negedge clk);
  endtask

  // Master shifts out nbits of tx; optionally offers sc_data in the slave's slot-start cycle.
  task automatic spi_byte(input logic [7:0] tx, input int nbits, input bit sc_load,
                          input logic [7:0] sc_data, output logic [7:0] got, output logic [7:0] exp);
    got = 8'h00;
    exp = 8'h00;
    if (nbits == 8) rx_q.push_back(tx);
    for (int i = 7; i > 7 - nbits; i--) begin
      @(negedge clk);
      SCK  = 1'b0;
      MOSI = tx[i];
      if (i == 7) begin
        exp    = m_full ? m_hold : empty_slot_byte();
        m_full = 1'b0;
      end
      if (i == 7 && sc_load) begin
        repeat (S) @(negedge clk);
        tx_byte  = sc_data;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
        m_hold   = sc_data;
        m_full   = 1'b1;
        repeat (H - S - 2) @(negedge clk);
      end else begin
        repeat (H - 1) @(negedge clk);
      end
      got[i] = MISO;
      @(negedge clk);
      SCK = 1'b1;
      repeat (H - 1) @(negedge clk);
    end
  endtask

  initial begin
    SS = 1'b1; SCK = 1'b1; MOSI = 1'b0; tx_valid = 1'b0; tx_byte = 8'h00;
    rst = 1'b1; checking = 1'b0; m_full = 1'b0; m_hold = 8'h00; m_last_rx = 8'h00;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_miso", MISO, 1'b1);
    check("rst_miso_oe", MISO_oe, 1'b0);
    check("rst_tx_ready", tx_ready, 1'b1);
    check("rst_rx_valid", rx_valid, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_rx_byte", rx_byte, 8'h00);
    checking = 1'b1;

    // single byte
    tx_load(8'hA5);
    frame_start();
    spi_byte(8'h3C, 8, 1'b0, 8'h00, g0, e0);
    check("single_tx_ready_back", tx_ready, 1'b1);
    frame_end();
    check("single_miso_literal", g0, 8'hA5);
    check("single_miso_model", g0, e0);
    check("single_rx_literal", rx_byte, 8'h3C);

    // underrun
    frame_start();
    spi_byte(8'h0F, 8, 1'b0, 8'h00, g0, e0);
    frame_end();
`ifdef SPI_SLAVE_ECHO_EN
    check("underrun_literal", g0, 8'h3C);
`else
    check("underrun_literal", g0, 8'hFF);
`endif
    check("underrun_model", g0, e0);

    // back-to-back, with an ignored offer while the holding register is full
    tx_load(8'h11);
    @(negedge clk);
    tx_byte = 8'h99; tx_valid = 1'b1;
    @(negedge clk);
    tx_valid = 1'b0;
    check("ignored_offer_ready", tx_ready, 1'b0);
    fork
      begin
        frame_start();
        spi_byte(8'h55, 8, 1'b0, 8'h00, g0, e0);
        spi_byte(8'hAA, 8, 1'b0, 8'h00, g1, e1);
        frame_end();
      end
      begin
        repeat (40) @(negedge clk);
        tx_load(8'h22);
      end
    join
    check("b2b_byte0_literal", g0, 8'h11);
    check("b2b_byte1_literal", g1, 8'h22);
    check("b2b_byte0_model", g0, e0);
    check("b2b_byte1_model", g1, e1);
    check("b2b_rx_last", rx_byte, 8'hAA);

    // abort after 4 rises, then a clean frame
    frame_start();
    spi_byte(8'hF0, 4, 1'b0, 8'h00, g0, e0);
    frame_end();
    check("abort_oe", MISO_oe, 1'b0);
    check("abort_rx_kept", rx_byte, 8'hAA);
    frame_start();
    spi_byte(8'hC3, 8, 1'b0, 8'h00, g0, e0);
    frame_end();
    check("after_abort_rx", rx_byte, 8'hC3);
    check("after_abort_miso_model", g0, e0);

    // handshake in the same cycle as the first slot start
    frame_start();
    spi_byte(8'h12, 8, 1'b1, 8'h77, g0, e0);
    spi_byte(8'h34, 8, 1'b0, 8'h00, g1, e1);
    frame_end();
`ifdef SPI_SLAVE_ECHO_EN
    check("same_cycle_byte0_literal", g0, 8'hC3);
`else
    check("same_cycle_byte0_literal", g0, 8'hFF);
`endif
    check("same_cycle_byte1_literal", g1, 8'h77);
    check("same_cycle_byte0_model", g0, e0);
    check("same_cycle_byte1_model", g1, e1);
    check("same_cycle_ready", tx_ready, 1'b1);

    repeat (4) @(negedge clk);
    check("rx_all_seen", rx_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/spi_slave.md
Name: spi_slave

Overview:
SPI mode-3 (CPOL=1, CPHA=1) slave endpoint, MSB first, 8-bit bytes, back-to-back bytes while SS stays low. It is the far end of the team's spi_master:
- samples MOSI on SCK rising edge;
- drives MISO on SCK falling edge;
- oversamples all SPI pins in the local clk domain.

It exposes a one-deep TX holding register with a valid/ready handshake and a one-cycle RX byte strobe.

Parameters:
SYNC_STAGES, 2, synchronizer flops on SS/SCK/MOSI (min 2).
TX_DEFAULT, 8'hFF, byte shifted out when no TX byte is held.

Ports:
clk  input  1  system clock
rst  input  1  synchronous active-high reset
tx_byte  input  8  byte to send on a later SPI byte slot
tx_valid  input  1  tx_byte valid; accepted when tx_valid & tx_ready
tx_ready  output  1  TX holding register empty
rx_byte  output  8  last fully received byte
rx_valid  output  1  one-cycle strobe, rx_byte updated
busy  output  1  synchronized SS is low (frame active)
SS  input  1  slave select, active low
SCK  input  1  SPI clock, idles high
MOSI  input  1  master-out data
MISO  output  1  slave-out data
MISO_oe  output  1  MISO output enable (1 = drive pad)

Behaviour:
- Reset (rst=1 at posedge clk): MISO=1, MISO_oe=0, rx_byte=0, rx_valid=0, tx_ready=1, busy=0.
  - Internal state: bit_cnt=0, shift registers=0, holding empty, FSM=ST_IDLE.
- Input path:
  - SS, SCK and MOSI each pass through SYNC_STAGES flops.
  - SS_s, SCK_s and MOSI_s are the synchronized outputs; SCK_d is SCK_s delayed one clk.
  - Edges: rise = !SCK_d & SCK_s; fall = SCK_d & !SCK_s.
  - Timing requirement on the bus: SCK high and low phases each ≥ SYNC_STAGES+3 clk cycles.
- FSM, 2 states:
  - ST_IDLE -> ST_ACTIVE when SS_s=0.
  - ST_ACTIVE -> ST_IDLE when SS_s=1, from any bit position.
  - busy=1 in ST_ACTIVE; MISO_oe=busy.
- TX holding register:
  - tx_ready = holding empty.
  - tx_valid & tx_ready loads holding and drops tx_ready on the next cycle.
  - tx_valid is ignored while tx_ready=0.
- Falling edge in ST_ACTIVE with bit_cnt==0 (start of a byte slot):
  - if holding is full, tx_shift <= holding, holding is emptied, tx_ready=1 on the next cycle;
  - otherwise tx_shift <= TX_DEFAULT;
  - MISO <= bit 7 of the loaded byte in the same cycle.
- Falling edge with bit_cnt!=0: MISO <= tx_shift[7-bit_cnt].
- Rising edge in ST_ACTIVE:
  - rx_shift <= {rx_shift[6:0], MOSI_s}; bit_cnt <= bit_cnt+1 (3-bit, wraps 7 -> 0).
  - On the rise with bit_cnt==7: rx_byte <= {rx_shift[6:0], MOSI_s}; rx_valid=1 for exactly one clk.
  - The next byte slot begins at the next falling edge.
- Same-cycle handshake and byte-slot load: the load uses holding contents from before the handshake.
  - If holding was empty, TX_DEFAULT is sent and the new byte stays held for the following slot.
  - No bypass path.
- SS_s rising (end or abort of frame):
  - bit_cnt=0; partial rx_shift discarded, no rx_valid;
  - MISO=1, MISO_oe=0;
  - an unconsumed holding byte is retained; a partially shifted byte is lost.
- Edges on SCK while in ST_IDLE are ignored.
- rst asserted mid-frame returns everything to reset values. The next frame starts only after SS_s goes high then low again; resuming mid-frame is not supported.
- rx_valid has no back-pressure: the consumer must take rx_byte within 8 SCK rising edges.

Optional Feature:
SPI_SLAVE_ECHO_EN
- Defined: a byte slot with an empty holding register sends the last received rx_byte instead of TX_DEFAULT. After reset this value is 8'h00.
- Undefined: empty slots send TX_DEFAULT.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: assert rst 2 cycles with SS=1 -> MISO=1, MISO_oe=0, tx_ready=1, rx_valid=0, busy=0.
- Single byte: preload tx_byte=8'hA5; master sends 8'h3C in one frame -> MISO bits sampled on SCK rise = 1,0,1,0,0,1,0,1; one rx_valid pulse with rx_byte=8'h3C; tx_ready returns 1 after the first falling edge.
- Back-to-back: load 8'h11, then 8'h22 during byte 0; master sends 8'h55, 8'hAA without raising SS -> master receives 8'h11, 8'h22; rx_valid pulses twice with 8'h55 then 8'hAA.
- Underrun: no tx byte loaded, master sends 8'h0F -> master receives 8'hFF (8'h00 with SPI_SLAVE_ECHO_EN; with a previously received 8'h3C, receives 8'h3C).
- Abort: SS raised after 4 SCK rises -> no rx_valid, MISO_oe=0, bit_cnt=0. The next full frame sending 8'hC3 gives rx_byte=8'hC3.
- Same-cycle load: tx_valid with 8'h77 in the same clk as the first falling-edge detect, holding empty -> byte 0 = 8'hFF, byte 1 = 8'h77.
